// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared defaults and helpers for the round-robin packet router
//  Revision    : 1.0  initial release
// ============================================================================
package router_pkg;

    localparam int c_DEF_DATA_WIDTH = 32;
    localparam int c_DEF_NUM_PORTS  = 4;
    localparam int c_DEF_FIFO_DEPTH = 4;

    // ceil(log2(value)), never less than 1 so a 1-bit field always exists
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < value) begin
                r = k + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_in_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : router_in_fifo
//  Description : Per-input synchronous FIFO holding {dest, data} words
//  Revision    : 1.0  initial release
// ============================================================================
module router_in_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // count is one bit wider than the pointers so full and empty never alias
    assign o_full    = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_packet_router.sv
`default_nettype none
// ============================================================================
//  Module      : rr_packet_router
//  Description : NxN destination-steered router, per-input FIFOs and
//                per-output round-robin arbitration into registered outputs
//  Revision    : 1.0  initial release
// ============================================================================
module rr_packet_router
    import router_pkg::*;
#(
    parameter int  DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int  NUM_PORTS  = c_DEF_NUM_PORTS,
    parameter int  FIFO_DEPTH = c_DEF_FIFO_DEPTH,
    localparam int DEST_WIDTH = clog2_min1(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_PORTS*DEST_WIDTH-1:0]  in_dest,
    input  logic [NUM_PORTS-1:0]             in_valid,
    output logic [NUM_PORTS-1:0]             in_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  out_data,
    output logic [NUM_PORTS*DEST_WIDTH-1:0]  out_src,
    output logic [NUM_PORTS-1:0]             out_valid,
    input  logic [NUM_PORTS-1:0]             out_ready,
    output logic [NUM_PORTS-1:0]             drop_pulse
);
    localparam int c_FW = DATA_WIDTH + DEST_WIDTH;

    logic [c_FW-1:0]       w_head      [NUM_PORTS];
    logic [DEST_WIDTH-1:0] w_head_dest [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_head_data [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_grant     [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_full;
    logic [NUM_PORTS-1:0]  w_empty;
    logic [NUM_PORTS-1:0]  w_push;
    logic [NUM_PORTS-1:0]  w_pop;
    logic [NUM_PORTS-1:0]  w_drop;
    logic [NUM_PORTS-1:0]  r_drop_pulse;

    // no bypass: a full FIFO refuses a word even when its head leaves this cycle
    assign in_ready   = ~w_full & {NUM_PORTS{~reset}};
    assign w_push     = in_valid & in_ready;
    assign drop_pulse = r_drop_pulse;

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
            router_in_fifo #(
                .WIDTH (c_FW),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (reset),
                .i_push  (w_push[i]),
                .i_data  ({in_dest[i*DEST_WIDTH +: DEST_WIDTH],
                           in_data[i*DATA_WIDTH +: DATA_WIDTH]}),
                .i_pop   (w_pop[i]),
                .o_head  (w_head[i]),
                .o_full  (w_full[i]),
                .o_empty (w_empty[i])
            );

            assign w_head_dest[i] = w_head[i][c_FW-1 -: DEST_WIDTH];
            assign w_head_data[i] = w_head[i][DATA_WIDTH-1:0];
            // out-of-range destinations exist only for non power-of-2 port counts
            assign w_drop[i] = !w_empty[i] &&
                               ({1'b0, w_head_dest[i]} >= (DEST_WIDTH+1)'(NUM_PORTS));
        end
    endgenerate

    always_comb begin
        w_pop = w_drop;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_pop = w_pop | w_grant[o];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_pulse <= '0;
        end else begin
            r_drop_pulse <= w_drop;
        end
    end

    generate
        for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
            logic [NUM_PORTS-1:0]  w_req;
            logic [NUM_PORTS-1:0]  w_gnt;
            logic                  w_slot_free;
            logic                  w_found_hi;
            logic                  w_found_lo;
            logic [DEST_WIDTH-1:0] w_win_hi;
            logic [DEST_WIDTH-1:0] w_win_lo;
            logic                  w_found;
            logic [DEST_WIDTH-1:0] w_winner;
            logic                  r_valid;
            logic [DATA_WIDTH-1:0] r_data;
            logic [DEST_WIDTH-1:0] r_src;
            logic [DEST_WIDTH-1:0] r_last_grant;

            always_comb begin
                w_req = '0;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    w_req[i] = !w_empty[i] && (w_head_dest[i] == DEST_WIDTH'(o));
                end
            end

            // Round robin as two priority scans: lowest requester above the last
            // winner, else lowest requester at or below it (the wrapped range).
            always_comb begin
                w_found_hi = 1'b0;
                w_found_lo = 1'b0;
                w_win_hi   = '0;
                w_win_lo   = '0;
                for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                    if (w_req[i]) begin
                        if (DEST_WIDTH'(i) > r_last_grant) begin
                            w_found_hi = 1'b1;
                            w_win_hi   = DEST_WIDTH'(i);
                        end else begin
                            w_found_lo = 1'b1;
                            w_win_lo   = DEST_WIDTH'(i);
                        end
                    end
                end
            end

            assign w_slot_free = !r_valid || out_ready[o];
            assign w_found     = w_found_hi || w_found_lo;
            assign w_winner    = w_found_hi ? w_win_hi : w_win_lo;

            always_comb begin
                w_gnt = '0;
                if (w_slot_free && w_found) begin
                    w_gnt[w_winner] = 1'b1;
                end
            end

            assign w_grant[o] = w_gnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid      <= 1'b0;
                    r_data       <= '0;
                    r_src        <= '0;
                    r_last_grant <= DEST_WIDTH'(NUM_PORTS - 1);
                end else if (w_slot_free) begin
                    if (w_found) begin
                        r_valid      <= 1'b1;
                        r_data       <= w_head_data[w_winner];
                        r_src        <= w_winner;
                        r_last_grant <= w_winner;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
            end

            assign out_valid[o]                           = r_valid;
            assign out_data[o*DATA_WIDTH +: DATA_WIDTH]   = r_data;
            assign out_src[o*DEST_WIDTH +: DEST_WIDTH]    = r_src;
        end
    endgenerate

endmodule
`default_nettype wire
